axis_pattern_source: RTL and testbench

AXIS_PATTERN_SOURCE -- requirements
Module: axis_pattern_source

---
 rtl/axis_pattern_source.sv | 135 +++++++++++++
 tb/tb_axis_pattern_source.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/axis_pattern_source.sv
// AXI4-Stream pattern generator: bursts of counter or LFSR data with optional
// single-beat bit-0 corruption, tracked by busy/done/beat_count.
module axis_pattern_source #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter bit          LFSR_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic [DATA_WIDTH-1:0] seed,
    input  logic                  mode,
    input  logic                  inject_en,
    input  logic [LEN_WIDTH-1:0]  inject_index,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  beat_count
);

    localparam logic [DATA_WIDTH-1:0] LFSR_TAPS = DATA_WIDTH'(32'h8020_0003);
    localparam logic [DATA_WIDTH-1:0] BIT0      = DATA_WIDTH'(1);

    // The LFSR polynomial is only meaningful on a 32-bit datapath.
    if (LFSR_EN && DATA_WIDTH != 32) begin : g_lfsr_width_check
        $error("axis_pattern_source: LFSR mode requires DATA_WIDTH = 32");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t                state;
    logic [LEN_WIDTH-1:0]  cfg_len;
    logic                  cfg_lfsr;
    logic                  cfg_inj_en;
    logic [LEN_WIDTH-1:0]  cfg_inj_idx;
    logic [DATA_WIDTH-1:0] pattern;
    logic [LEN_WIDTH-1:0]  beat_idx;

    logic                  start_lfsr;
    logic [DATA_WIDTH-1:0] first_pattern;
    logic [DATA_WIDTH-1:0] first_mask;
    logic [DATA_WIDTH-1:0] next_pattern;
    logic [LEN_WIDTH-1:0]  next_idx;
    logic [DATA_WIDTH-1:0] next_mask;
    logic                  next_is_last;

    // Pattern arithmetic for the beat being loaded into the output register.
    always_comb begin
        start_lfsr    = LFSR_EN && mode;
        first_pattern = (start_lfsr && seed == '0) ? BIT0 : seed;
        first_mask    = (inject_en && inject_index == '0) ? BIT0 : '0;
        next_idx      = beat_idx + LEN_WIDTH'(1);
        next_mask     = (cfg_inj_en && cfg_inj_idx == next_idx) ? BIT0 : '0;
        next_is_last  = (next_idx == cfg_len - LEN_WIDTH'(1));
        if (cfg_lfsr) begin
            next_pattern = (pattern >> 1) ^ (pattern[0] ? LFSR_TAPS : '0);
        end else begin
            next_pattern = pattern + BIT0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cfg_len     <= '0;
            cfg_lfsr    <= 1'b0;
            cfg_inj_en  <= 1'b0;
            cfg_inj_idx <= '0;
            pattern     <= '0;
            beat_idx    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            beat_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_len     <= length;
                        cfg_lfsr    <= start_lfsr;
                        cfg_inj_en  <= inject_en;
                        cfg_inj_idx <= inject_index;
                        beat_count  <= '0;
                        busy        <= 1'b1;
                        if (length != '0) begin
                            state     <= SEND;
                            pattern   <= first_pattern;
                            beat_idx  <= '0;
                            out_valid <= 1'b1;
                            out_data  <= first_pattern ^ first_mask;
                            out_last  <= (length == LEN_WIDTH'(1));
                        end else begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end
                    end
                end
                SEND: begin
                    if (out_valid && out_ready) begin
                        beat_count <= beat_count + LEN_WIDTH'(1);
                        if (out_last) begin
                            state     <= FINISH;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            // Mask applies to the output only; pattern stays clean.
                            pattern  <= next_pattern;
                            beat_idx <= next_idx;
                            out_data <= next_pattern ^ next_mask;
                            out_last <= next_is_last;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_pattern_source.sv
// Randomized and directed bench for axis_pattern_source against a closed-form
// model of the counter/LFSR/injection rules.
module tb_axis_pattern_source;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] length;
    logic [31:0] seed;
    logic        mode;
    logic        inject_en;
    logic [15:0] inject_index;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [15:0] beat_count;

    int checks = 0;
    int errors = 0;

    axis_pattern_source #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .length       (length),
        .seed         (seed),
        .mode         (mode),
        .inject_en    (inject_en),
        .inject_index (inject_index),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_last     (out_last),
        .out_ready    (out_ready),
        .busy         (busy),
        .done         (done),
        .beat_count   (beat_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Right-shifting Galois step for x^32 + x^22 + x^2 + x + 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        logic [31:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic [31:0] model_beat(input logic [31:0] sd, input logic md,
                                               input int unsigned i, input logic ie,
                                               input int unsigned ii);
        logic [31:0] p;
        if (!md) begin
            p = sd + 32'(i);
        end else begin
            p = (sd == 32'd0) ? 32'd1 : sd;
            for (int k = 0; k < int'(i); k++) p = lfsr_step(p);
        end
        if (ie && i == ii) p[0] = ~p[0];
        return p;
    endfunction

    // Called at a falling edge. rmode: 0 = always ready, 1 = toggle from 0, 2 = random.
    task automatic run_burst(input int unsigned len, input logic [31:0] sd, input logic md,
                             input logic ie, input int unsigned ii, input int rmode,
                             input bit poke);
        int unsigned got;
        bit          done_seen;
        bit          poked;
        logic        rdy;
        logic        tog;
        got = 0; done_seen = 0; poked = 0; tog = 1'b0;
        start = 1'b1; length = 16'(len); seed = sd; mode = md;
        inject_en = ie; inject_index = 16'(ii);
        @(negedge clk);
        for (int cyc = 0; cyc < 400 && !done_seen; cyc++) begin
            start = 1'b0;
            check("beat_count", beat_count, 64'(got));
            if (done) begin
                done_seen = 1;
                check("done_valid", out_valid, 0);
                check("done_busy", busy, 1);
                check("handshakes", 64'(got), 64'(len));
            end else begin
                check("busy", busy, 1);
                check("valid", out_valid, 1);
                if (got >= len) begin
                    check("extra_beat", 64'(got), 64'(len) - 1);
                    break;
                end
                check("data", out_data, model_beat(sd, md, got, ie, ii));
                check("last", out_last, 64'(got == len - 1));
                case (rmode)
                    0:       rdy = 1'b1;
                    1:       begin rdy = tog; tog = ~tog; end
                    default: rdy = 1'($urandom_range(0, 1));
                endcase
                out_ready = rdy;
                if (rdy) got++;
                if (poke && !poked && got == 1) begin
                    poked = 1; start = 1'b1; length = 16'd2; seed = 32'h55; mode = ~md;
                end
                @(negedge clk);
            end
        end
        check("done_seen", 64'(done_seen), 1);
        out_ready = 1'b0;
        @(negedge clk);
        check("post_done", done, 0);
        check("post_busy", busy, 0);
        check("post_valid", out_valid, 0);
        check("held_count", beat_count, 64'(len));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; length = '0; seed = '0; mode = 1'b0;
        inject_en = 1'b0; inject_index = '0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", beat_count, 0);
        reset = 1'b0;
        @(negedge clk);

        run_burst(4, 32'hFFFF_FFFE, 1'b0, 1'b0, 0, 0, 0);   // counter wrap
        run_burst(3, 32'd10, 1'b0, 1'b0, 0, 1, 0);          // toggling backpressure
        run_burst(5, 32'd100, 1'b0, 1'b1, 2, 0, 0);         // injection at beat 2
        run_burst(3, 32'd0, 1'b1, 1'b0, 0, 0, 0);           // LFSR, zero seed
        run_burst(3, 32'd1, 1'b1, 1'b0, 0, 0, 0);           // LFSR, seed 1
        run_burst(0, 32'd7, 1'b0, 1'b0, 0, 0, 0);           // zero length
        run_burst(6, 32'd20, 1'b0, 1'b0, 0, 0, 1);          // start pulsed mid-burst
        run_burst(4, 32'd50, 1'b0, 1'b1, 9, 2, 0);          // inject index beyond length
        run_burst(1, 32'hDEAD_BEEF, 1'b1, 1'b1, 0, 1, 0);   // single beat, injected

        // Reset during a running burst.
        @(negedge clk);
        start = 1'b1; length = 16'd8; seed = 32'd300; mode = 1'b0;
        inject_en = 1'b0; inject_index = '0; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_count", beat_count, 2);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", beat_count, 0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_done_after_rst", done, 0);
            check("idle_after_rst", out_valid, 0);
        end
        run_burst(8, 32'd300, 1'b0, 1'b0, 0, 0, 0);

        for (int n = 0; n < 25; n++) begin
            run_burst($urandom_range(0, 10), $urandom, 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), $urandom_range(0, 12), 2,
                      bit'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
